// File: rtl/p2_pkg.sv
// Shared constants for the phased 16-bit core: default widths, register count
// helper and instruction field positions used by the decode wrapper.
package p2_pkg;

    localparam int P2_DATA_W = 16;
    localparam int P2_ADDR_W = 3;

    // Source / destination register fields inside a 16-bit instruction word
    localparam int RS_MSB = 13;
    localparam int RS_LSB = 11;
    localparam int RD_MSB = 10;
    localparam int RD_LSB = 8;

    function automatic int p2_nregs(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/p2_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by a claim and cleared
// by write-back, plus read-after-write hazard lookup for both decode sources.
module p2_scoreboard
    import p2_pkg::*;
#(
    parameter int ADDR_W   = P2_ADDR_W,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1,
    localparam int NREGS   = p2_nregs(ADDR_W)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              flush,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              hazard_rs,
    output logic              hazard_rd,
    output logic [NREGS-1:0]  pending
);

    logic [NREGS-1:0] pending_reg;
    logic [NREGS-1:0] pending_next;

    // Priority: flush, then claim, then write-back. A same-cycle claim beats the
    // write so the newer instruction keeps ownership of the register.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_bit
            if (ZERO_REG != 0 && gi == 0) begin : g_zero
                assign pending_next[gi] = 1'b0;
            end else begin : g_live
                assign pending_next[gi] =
                    flush                                     ? 1'b0 :
                    (claim_en && claim_addr == ADDR_W'(gi))   ? 1'b1 :
                    (wr_en && wr_addr == ADDR_W'(gi))         ? 1'b0 :
                                                                pending_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    logic fwd_rs, fwd_rd;
    logic zero_rs, zero_rd;

    // A same-cycle write-back resolves the hazard only when it can be forwarded.
    assign fwd_rs  = (BYPASS != 0) && wr_en && (wr_addr == rs_addr);
    assign fwd_rd  = (BYPASS != 0) && wr_en && (wr_addr == rd_addr);
    assign zero_rs = (ZERO_REG != 0) && (rs_addr == '0);
    assign zero_rd = (ZERO_REG != 0) && (rd_addr == '0);

    assign hazard_rs = pending_reg[rs_addr] && !fwd_rs && !zero_rs;
    assign hazard_rd = pending_reg[rd_addr] && !fwd_rd && !zero_rd;
    assign pending   = pending_reg;

endmodule

// File: rtl/p2_regfile_fwd.sv
// Decode-stage register file: two registered read ports with optional
// write-to-read bypass, one write port, and scoreboard-driven decode stall.
module p2_regfile_fwd
    import p2_pkg::*;
#(
    parameter int DATA_W   = P2_DATA_W,
    parameter int ADDR_W   = P2_ADDR_W,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1,
    localparam int NREGS   = p2_nregs(ADDR_W)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              decode_en,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flush,
    output logic [DATA_W-1:0] ar,
    output logic [DATA_W-1:0] br,
    output logic              operands_valid,
    output logic              stall,
    output logic [NREGS-1:0]  pending
);

    logic [DATA_W-1:0] regs_reg [NREGS];
    logic [DATA_W-1:0] ar_reg, br_reg;
    logic [DATA_W-1:0] ar_next, br_next;
    logic              valid_reg;
    logic              hazard_rs, hazard_rd;
    logic              wr_allowed;

    p2_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clock      (clock),
        .reset      (reset),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .flush      (flush),
        .rs_addr    (rs_addr),
        .rd_addr    (rd_addr),
        .hazard_rs  (hazard_rs),
        .hazard_rd  (hazard_rd),
        .pending    (pending)
    );

    assign wr_allowed = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wr_allowed) begin
            regs_reg[wr_addr] <= wr_data;
        end
    end

    // Effective read value: hardwired zero beats bypass, bypass beats the array.
    always_comb begin
        ar_next = regs_reg[rs_addr];
        br_next = regs_reg[rd_addr];
        if ((BYPASS != 0) && wr_en && (wr_addr == rs_addr)) ar_next = wr_data;
        if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr)) br_next = wr_data;
        if ((ZERO_REG != 0) && (rs_addr == '0)) ar_next = '0;
        if ((ZERO_REG != 0) && (rd_addr == '0)) br_next = '0;
    end

    assign stall = decode_en && (hazard_rs || hazard_rd);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ar_reg    <= '0;
            br_reg    <= '0;
            valid_reg <= 1'b0;
        end else if (decode_en && !stall) begin
            ar_reg    <= ar_next;
            br_reg    <= br_next;
            valid_reg <= 1'b1;
        end else begin
            valid_reg <= 1'b0;
        end
    end

    assign ar             = ar_reg;
    assign br             = br_reg;
    assign operands_valid = valid_reg;

endmodule

// File: doc/p2_regfile_fwd.md
Name: p2_regfile_fwd

Overview:
Parametrised successor to the decode-stage register file in the phased 16-bit core. It holds 2^ADDR_W general registers, with two registered read ports (ar/br), one write port, write-to-read bypass and a per-register pending-write scoreboard. Decode stalls on read-after-write hazards. Explicit enables replace phase-counter decoding, so the block serves both the multi-cycle and pipelined variants of the core.

Parameters:
DATA_W, 16, register and operand width
ADDR_W, 3, register address width; NREGS = 2**ADDR_W
ZERO_REG, 0, 1 = register 0 reads as zero and ignores writes and claims
BYPASS, 1, 1 = same-cycle write data forwarded to decode reads

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
decode_en  in  1  request to read operands this cycle
rs_addr  in  ADDR_W  source address for ar
rd_addr  in  ADDR_W  source address for br
claim_en  in  1  mark claim_addr as pending write (issued instruction)
claim_addr  in  ADDR_W  destination being claimed
wr_en  in  1  write-back strobe
wr_addr  in  ADDR_W  write-back address
wr_data  in  DATA_W  write-back data
flush  in  1  clear all pending bits (squash)
ar  out  DATA_W  registered operand A
br  out  DATA_W  registered operand B
operands_valid  out  1  pulse: ar/br updated by a successful decode last edge
stall  out  1  combinational: decode_en with unresolved hazard this cycle
pending  out  NREGS  scoreboard bitmap, bit i = register i awaiting write

Behaviour:
- Reset (async, active-high): all registers, ar, br = 0; pending = 0; operands_valid = 0. Reset asserted mid-operation discards any in-flight write or claim. stall reads 0 while reset is high.
- Write: on the rising edge with wr_en=1, reg[wr_addr] <= wr_data. With ZERO_REG=1, writes to address 0 are dropped.
- Read value of an address a (eff(a)):
  - ZERO_REG=1 and a=0: 0.
  - BYPASS=1, wr_en=1 and wr_addr=a: wr_data.
  - Otherwise: reg[a].
- Hazard(a) = pending[a] and not (BYPASS and wr_en and wr_addr==a). With ZERO_REG=1, address 0 never hazards.
- stall = decode_en and (hazard(rs_addr) or hazard(rd_addr)). Purely combinational, for upstream hold.
- Decode:
  - decode_en=1 and stall=0: at the edge ar <= eff(rs_addr), br <= eff(rd_addr), operands_valid <= 1. Latency is one cycle.
  - decode_en=1 and stall=1: ar/br hold, operands_valid <= 0.
  - decode_en=0: ar/br hold, operands_valid <= 0.
- Scoreboard update per bit i, in priority order:
  - flush: 0.
  - claim_en and claim_addr==i: 1.
  - wr_en and wr_addr==i: 0.
  - Otherwise: hold.
- Consequences of that order:
  - A claim and a write to the same register in one cycle leave the bit set: the newer instruction owns it.
  - flush overrides a same-cycle claim.
  - A write to a non-pending register is legal and leaves the bit at 0.
  - ZERO_REG=1: bit 0 is held at 0.
- The block does not gate claim_en with stall. Upstream must not claim while stalled.
- The write and the decode read of the same register at the same edge give the new data when BYPASS=1 and the old data when BYPASS=0 (pure write-after-read). With BYPASS=0 a same-cycle write does not clear the hazard.
- All sequential logic is on the rising edge. Outputs ar, br and operands_valid come straight from flops.

Decomposition:
- Shared package p2_pkg holds:
  - default DATA_W and ADDR_W;
  - a helper function computing NREGS;
  - instruction field constants RS_MSB=13, RS_LSB=11, RD_MSB=10, RD_LSB=8, so the decode wrapper slices rs/rd consistently.
- One natural sub-module: p2_scoreboard. It contains the pending bitmap, the priority update and the hazard lookup, is parametrised by ADDR_W and ZERO_REG, and is verifiable standalone.
- Register array, bypass muxes and operand flops stay in p2_regfile_fwd.

Test Plan:
- Reset with default params, then write 0x1234 to r3 and decode rs=3, rd=0 in the next cycle -> ar=0x1234, br=0, operands_valid=1 for exactly one cycle.
- Same-cycle wr_en r5=0xBEEF with decode rs=5: with BYPASS=1 -> ar=0xBEEF; with BYPASS=0 -> ar=old r5 (0). In both cases r5=0xBEEF afterwards.
- Claim r2, then decode rs=2 -> stall=1 and ar unchanged. Two cycles later write r2=0x00AA (BYPASS=1) with decode held -> stall=0 that cycle, ar=0x00AA, pending[2]=0.
- Same-cycle claim r4 and write r4=0x5555 -> r4=0x5555, pending[4]=1. Then flush -> pending=0 and decode rs=4 proceeds with ar=0x5555.
- ZERO_REG=1: write r0=0xFFFF, then claim r0, then decode rs=0 -> no stall, ar=0, pending[0]=0.
- Assert reset asynchronously mid-cycle with pending=0x0C and ar=0x1234 -> ar, br, pending and operands_valid clear immediately without a clock edge. DATA_W=32, ADDR_W=4 run repeats scenario 1 with r15=0xDEADBEEF.
